spi_slave_rx: RTL and testbench

Receive-side SPI stage that sits directly downstream of the team's 16-bit SPI master transmitter. It consumes the master's `spi_mclk`, `spi_dat` and `spi_ssal` lines, samples them in the system `clk` domain and deserializes MSB-first 16-bit words. Each word is presented on a registered valid/ready output port, with sticky overrun and framing-error reporting, for the downstream datapath.

---
 rtl/spi_slave_rx.sv | 210 +++++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI receive stage: deserializes MSB-first 16-bit words from the SPI master into a valid/ready port.
// Optional macro SPI_RX_SYNC_EN selects 2-flop input synchronizers (default: single register stage).
module spi_slave_rx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_mclk_i,
  input  logic             spi_dat_i,
  input  logic             spi_ssal_i,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             rx_overrun_o,
  output logic             frame_err_o,
  input  logic             clr_err_i,
  output logic [4:0]       rx_bit_count_o
);

  localparam logic [4:0] CNT_FULL = 5'd16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT      = 2'd1,
    WAIT_DESEL = 2'd2,
    ILLEGAL    = 2'd3
  } state_e;

  logic mclk_s, dat_s, ssal_s;
  logic mclk_d_q;
  logic rise_s;

`ifdef SPI_RX_SYNC_EN
  logic [1:0] mclk_sync_q, dat_sync_q, ssal_sync_q;

  // Two-stage synchronizers, identical on all three lines to keep them aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mclk_sync_q <= 2'b00;
      dat_sync_q  <= 2'b00;
      ssal_sync_q <= 2'b11;
    end else begin
      mclk_sync_q <= {mclk_sync_q[0], spi_mclk_i};
      dat_sync_q  <= {dat_sync_q[0], spi_dat_i};
      ssal_sync_q <= {ssal_sync_q[0], spi_ssal_i};
    end
  end

  assign mclk_s = mclk_sync_q[1];
  assign dat_s  = dat_sync_q[1];
  assign ssal_s = ssal_sync_q[1];
`else
  logic mclk_sync_q, dat_sync_q, ssal_sync_q;

  // Single capture stage; only valid when the master shares this clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mclk_sync_q <= 1'b0;
      dat_sync_q  <= 1'b0;
      ssal_sync_q <= 1'b1;
    end else begin
      mclk_sync_q <= spi_mclk_i;
      dat_sync_q  <= spi_dat_i;
      ssal_sync_q <= spi_ssal_i;
    end
  end

  assign mclk_s = mclk_sync_q;
  assign dat_s  = dat_sync_q;
  assign ssal_s = ssal_sync_q;
`endif

  // Delayed copy of the synchronized serial clock for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mclk_d_q <= 1'b0;
    end else begin
      mclk_d_q <= mclk_s;
    end
  end

  assign rise_s = mclk_s & ~mclk_d_q;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d, cnt_inc_s, cnt_new_s;
  logic [WIDTH-1:0] shift_q, shift_d, shift_inc_s;
  logic             frame_err_q, frame_err_d;
  logic             offer_s;

  // Receive FSM state, bit counter, shift register and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic; a rise is counted before a simultaneous deselect is judged
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    offer_s     = 1'b0;
    cnt_inc_s   = cnt_q + 5'd1;
    shift_inc_s = {shift_q[WIDTH-2:0], dat_s};
    cnt_new_s   = rise_s ? cnt_inc_s : cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d   = 5'd0;
        shift_d = '0;
        if (!ssal_s) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (rise_s) begin
          cnt_d   = cnt_inc_s;
          shift_d = shift_inc_s;
        end else begin
          cnt_d   = cnt_q;
          shift_d = shift_q;
        end
        if (rise_s && (cnt_inc_s == CNT_FULL)) begin
          offer_s = 1'b1;
          state_d = WAIT_DESEL;
        end else if (ssal_s) begin
          frame_err_d = (cnt_new_s != 5'd0);
          cnt_d       = 5'd0;
          shift_d     = '0;
          state_d     = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      WAIT_DESEL: begin
        frame_err_d = rise_s;
        if (ssal_s) begin
          cnt_d   = 5'd0;
          state_d = IDLE;
        end else begin
          state_d = WAIT_DESEL;
        end
      end
      default: begin
        cnt_d   = 5'd0;
        shift_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic             consume_s;

  assign consume_s = rx_valid_q & rx_ready_i;

  // Output handshake: consume first, then load; a blocked offer is dropped as overrun
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (offer_s && (!rx_valid_q || consume_s)) begin
      rx_data_d  = shift_inc_s;
      rx_valid_d = 1'b1;
    end else if (offer_s) begin
      overrun_d = 1'b1;
    end else if (consume_s) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
    if (clr_err_i && !(offer_s && rx_valid_q && !rx_ready_i)) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_d;
    end
  end

  // Registered output port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_overrun_o   = overrun_q;
  assign frame_err_o    = frame_err_q;
  assign rx_bit_count_o = cnt_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: directed words from a same-clock SPI master model.
module tb_spi_slave_rx;

`ifdef SPI_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_mclk, spi_dat, spi_ssal;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready, rx_overrun, frame_err, clr_err;
  logic [4:0]  rx_bit_count;

  int vectors = 0;
  int errors  = 0;
  int fe_cnt  = 0;
  int fe0;
  logic [15:0] sb[$];

  spi_slave_rx #(.WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi_mclk_i    (spi_mclk),
    .spi_dat_i     (spi_dat),
    .spi_ssal_i    (spi_ssal),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready),
    .rx_overrun_o  (rx_overrun),
    .frame_err_o   (frame_err),
    .clr_err_i     (clr_err),
    .rx_bit_count_o(rx_bit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send the low n bits of 'bits' MSB first; optionally check completion latency of a 16-bit word w
  task automatic send(input logic [31:0] bits, input int n, input bit chk_lat, input logic [15:0] w);
    spi_ssal = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mclk = 1'b0;
      spi_dat  = bits[i];
      tick();
      spi_mclk = 1'b1;
      if (chk_lat && i == 0) begin
        @(posedge clk);
        for (int k = 1; k <= LAT; k++) begin
          tick();
          if (k < LAT) begin
            chk("lat_valid_early", {31'd0, rx_valid}, 32'd0);
            chk("lat_cnt_early", {27'd0, rx_bit_count}, 32'd15);
          end else begin
            chk("lat_valid", {31'd0, rx_valid}, 32'd1);
            chk("lat_cnt16", {27'd0, rx_bit_count}, 32'd16);
            chk("lat_data", {16'd0, rx_data}, {16'd0, w});
          end
        end
      end else begin
        tick();
      end
    end
    spi_mclk = 1'b0;
    tick();
    spi_ssal = 1'b1;
    tick();
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected word
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL sb_unexpected: got word %h, expected none", rx_data);
      end else begin
        chk("sb_word", {16'd0, rx_data}, {16'd0, sb.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
  end

  initial begin
    rst_n    = 1'b0;
    spi_mclk = 1'b0;
    spi_dat  = 1'b0;
    spi_ssal = 1'b1;
    rx_ready = 1'b1;
    clr_err  = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_data", {16'd0, rx_data}, 32'd0);
    chk("rst_cnt", {27'd0, rx_bit_count}, 32'd0);
    chk("rst_ovr", {31'd0, rx_overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // single word
    fe0 = fe_cnt;
    sb.push_back(16'hA5C3);
    send({16'd0, 16'hA5C3}, 16, 1'b1, 16'hA5C3);
    repeat (4) tick();
    chk("single_fe", fe_cnt - fe0, 32'd0);
    chk("single_ovr", {31'd0, rx_overrun}, 32'd0);
    chk("single_cnt_idle", {27'd0, rx_bit_count}, 32'd0);

    // back-to-back words with 1-cycle deselect gaps
    fe0 = fe_cnt;
    sb.push_back(16'h1234);
    send({16'd0, 16'h1234}, 16, 1'b1, 16'h1234);
    sb.push_back(16'hFFFF);
    send({16'd0, 16'hFFFF}, 16, 1'b1, 16'hFFFF);
    sb.push_back(16'h0001);
    send({16'd0, 16'h0001}, 16, 1'b1, 16'h0001);
    repeat (4) tick();
    chk("b2b_fe", fe_cnt - fe0, 32'd0);
    chk("b2b_ovr", {31'd0, rx_overrun}, 32'd0);

    // overrun
    rx_ready = 1'b0;
    send({16'd0, 16'h00FF}, 16, 1'b0, 16'h0000);
    tick();
    chk("ovr_first_valid", {31'd0, rx_valid}, 32'd1);
    chk("ovr_first_data", {16'd0, rx_data}, 32'h0000_00FF);
    chk("ovr_first_flag", {31'd0, rx_overrun}, 32'd0);
    send({16'd0, 16'hAAAA}, 16, 1'b0, 16'h0000);
    tick();
    chk("ovr_data_kept", {16'd0, rx_data}, 32'h0000_00FF);
    chk("ovr_flag", {31'd0, rx_overrun}, 32'd1);
    sb.push_back(16'h00FF);
    rx_ready = 1'b1;
    tick();
    chk("ovr_consumed", {31'd0, rx_valid}, 32'd0);
    chk("ovr_sticky", {31'd0, rx_overrun}, 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovr_cleared", {31'd0, rx_overrun}, 32'd0);

    // abort after 5 bits, then a clean word
    fe0 = fe_cnt;
    send({27'd0, 5'b10110}, 5, 1'b0, 16'h0000);
    repeat (4) tick();
    chk("abort_fe", fe_cnt - fe0, 32'd1);
    chk("abort_cnt", {27'd0, rx_bit_count}, 32'd0);
    sb.push_back(16'h5A5A);
    send({16'd0, 16'h5A5A}, 16, 1'b1, 16'h5A5A);
    repeat (4) tick();
    chk("abort_next_fe", fe_cnt - fe0, 32'd1);

    // over-length: 17 edges, extra bit ignored
    fe0 = fe_cnt;
    sb.push_back(16'hC001);
    send({15'd0, 16'hC001, 1'b1}, 17, 1'b0, 16'h0000);
    repeat (4) tick();
    chk("olen_fe", fe_cnt - fe0, 32'd1);
    chk("olen_data", {16'd0, rx_data}, 32'h0000_C001);

    // asynchronous reset after 9 bits of 0xBEEF
    fe0 = fe_cnt;
    spi_ssal = 1'b0;
    for (int i = 15; i >= 7; i--) begin
      spi_mclk = 1'b0;
      spi_dat  = 1'(16'hBEEF >> i);
      tick();
      spi_mclk = 1'b1;
      tick();
    end
    repeat (3) tick();
    chk("pre_rst_cnt", {27'd0, rx_bit_count}, 32'd9);
    rst_n = 1'b0;
    #1;
    chk("arst_data", {16'd0, rx_data}, 32'd0);
    chk("arst_valid", {31'd0, rx_valid}, 32'd0);
    chk("arst_cnt", {27'd0, rx_bit_count}, 32'd0);
    chk("arst_fe", {31'd0, frame_err}, 32'd0);
    chk("arst_ovr", {31'd0, rx_overrun}, 32'd0);
    spi_mclk = 1'b0;
    spi_ssal = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    sb.push_back(16'h0F0F);
    send({16'd0, 16'h0F0F}, 16, 1'b1, 16'h0F0F);
    repeat (4) tick();
    chk("post_rst_fe", fe_cnt - fe0, 32'd0);
    chk("post_rst_ovr", {31'd0, rx_overrun}, 32'd0);

    for (int t = 0; t < 50 && sb.size() != 0; t++) tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
